// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter sharing a 16:1 result mux; registers the
//               winning word onto a valid/ready output with a one-cycle grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter #(
  parameter int IN_WIDTH  = 32,
  parameter int SEL_WIDTH = 4,
  localparam int N        = 1 << SEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N*IN_WIDTH-1:0] data_in,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic [N-1:0]          gnt,
  output logic [IN_WIDTH-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic [IN_WIDTH-1:0]  out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [15:0]          xfer_cnt_q, xfer_cnt_d;

  logic [IN_WIDTH-1:0]  slot [N];
  logic [2*N-1:0]       req_dbl;
  logic [N-1:0]         req_rot;
  logic [SEL_WIDTH-1:0] win_off;
  logic [SEL_WIDTH-1:0] win_idx;

  for (genvar g = 0; g < N; g++) begin : g_slot
    assign slot[g] = data_in[g*IN_WIDTH +: IN_WIDTH];
  end

  // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_q +: N];

  always_comb begin
    win_off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_rot[j]) win_off = SEL_WIDTH'(j);
    end
  end

  assign win_idx = ptr_q + win_off;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          sel_d       = win_idx;
          out_data_d  = slot[win_idx];
          out_valid_d = 1'b1;
          gnt_d       = N'(1) << win_idx;
          ptr_d       = win_idx + SEL_WIDTH'(1);
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          xfer_cnt_d  = xfer_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Directed and randomized bench for mux_rr_arbiter against a
//               behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

  localparam int W = 32;
  localparam int N = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [3:0]     sel;
  logic [N-1:0]   gnt;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    xfer_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the externally visible outputs.
  logic        m_init = 1'b0;
  logic        m_busy;
  int          m_ptr;
  logic [3:0]  m_sel;
  logic [15:0] m_gnt;
  logic [31:0] m_data;
  logic        m_valid;
  logic [15:0] m_cnt;

  mux_rr_arbiter #(.IN_WIDTH(W), .SEL_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .sel       (sel),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int k;
    if (!rst_n) begin
      m_init  = 1'b1;
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_sel   = '0;
      m_gnt   = '0;
      m_data  = '0;
      m_valid = 1'b0;
      m_cnt   = '0;
    end else if (m_init) begin
      m_gnt = '0;
      if (!m_busy) begin
        if (req != '0) begin
          k = -1;
          for (int i = 0; i < N; i++) begin
            if (k < 0 && req[(m_ptr + i) % N]) k = (m_ptr + i) % N;
          end
          m_sel   = 4'(k);
          m_data  = data_in[k*W +: W];
          m_valid = 1'b1;
          m_gnt   = 16'(1) << k;
          m_ptr   = (k + 1) % N;
          m_busy  = 1'b1;
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
        m_cnt   = m_cnt + 16'd1;
        m_busy  = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (m_init) begin
      chk("sel",       32'(sel),       32'(m_sel));
      chk("gnt",       32'(gnt),       32'(m_gnt));
      chk("out_data",  out_data,       m_data);
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_slot(input int k, input logic [31:0] v);
    data_in[k*W +: W] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 16'hFFFF;
    data_in   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) set_slot(i, 32'hA000 + 32'(i));

    // Reset with every requester asserting.
    tick();
    tick();
    chk("rst_sel",   32'(sel),       0);
    chk("rst_gnt",   32'(gnt),       0);
    chk("rst_data",  out_data,       0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_cnt",   32'(xfer_cnt),  0);
    chk("model_rst_valid", 32'(m_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;

    // Single request.
    @(negedge clk);
    req = 16'h0020;
    set_slot(5, 32'd5000);
    out_ready = 1'b1;
    tick();
    chk("single_sel",   32'(sel),       5);
    chk("single_data",  out_data,       5000);
    chk("single_gnt",   32'(gnt),       32'h0020);
    chk("single_valid", 32'(out_valid), 1);
    chk("model_single_sel", 32'(m_sel), 5);
    @(negedge clk);
    req = '0;
    tick();
    chk("single_valid_after", 32'(out_valid), 0);
    chk("single_cnt",         32'(xfer_cnt),  1);

    // Full rotation from a fresh pointer.
    for (int i = 0; i < N; i++) set_slot(i, 32'(1000 * i));
    do_reset();
    req = 16'hFFFF;
    out_ready = 1'b1;
    for (int n = 0; n < 17; n++) begin
      tick();
      chk("rot_sel",  32'(sel),  32'(n % 16));
      chk("rot_data", out_data,  32'(1000 * (n % 16)));
      chk("rot_gnt",  32'(gnt),  32'(16'(1) << (n % 16)));
      tick();
      chk("rot_cnt",  32'(xfer_cnt), 32'(n + 1));
    end
    chk("model_rot_cnt", 32'(m_cnt), 17);

    // Backpressure on slot 3.
    @(negedge clk);
    req = 16'h0008;
    set_slot(3, 32'd3000);
    out_ready = 1'b0;
    tick();
    chk("bp_gnt_first", 32'(gnt), 32'h0008);
    @(negedge clk);
    req = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_sel",   32'(sel),       3);
      chk("bp_data",  out_data,       3000);
      chk("bp_gnt",   32'(gnt),       0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    req = '0;
    tick();
    chk("bp_done_valid", 32'(out_valid), 0);
    chk("bp_done_cnt",   32'(xfer_cnt),  18);

    // Pointer wrap 14 -> 15 -> 0.
    @(negedge clk);
    req = 16'h4000;
    tick();
    chk("wrap_sel14", 32'(sel), 14);
    @(negedge clk);
    req = '0;
    tick();
    @(negedge clk);
    req = 16'h8001;
    tick();
    chk("wrap_sel15", 32'(sel), 15);
    tick();
    tick();
    chk("wrap_sel0",  32'(sel), 0);
    chk("wrap_gnt0",  32'(gnt), 32'h0001);
    @(negedge clk);
    req = '0;
    tick();

    // Reset during HOLD.
    @(negedge clk);
    req = 16'h0004;
    out_ready = 1'b0;
    tick();
    chk("mid_valid_pre", 32'(out_valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_cnt",   32'(xfer_cnt),  0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 16'hFFFF;
    tick();
    chk("mid_first_sel", 32'(sel), 0);
    chk("mid_first_gnt", 32'(gnt), 32'h0001);

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = 16'(1) << $urandom_range(0, 15);
        2:       req = 16'($urandom) & 16'($urandom);
        default: req = 16'hFFFF;
      endcase
      for (int i = 0; i < N; i++) set_slot(i, $urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
